// File: rtl/dct_transpose_buffer_pkg.sv
// Shared constants and types for the 8x8 DCT transpose buffer.
//   DCT_N      : block dimension (rows, columns, elements per vector)
//   DCT_IDX_W  : width of a row/column index
//   dct_idx_t  : row/column index type
// Element k of any packed vector lives at [k*DATA_WIDTH +: DATA_WIDTH].
package dct_transpose_buffer_pkg;

  localparam int unsigned DCT_N     = 8;
  localparam int unsigned DCT_IDX_W = 3;

  typedef logic [DCT_IDX_W-1:0] dct_idx_t;

  localparam dct_idx_t DctLastIdx = dct_idx_t'(DCT_N - 1);

endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 coefficient register array of the transpose buffer.
// Ports:
//   clk      : clock, writes on rising edge
//   we       : write enable for one full row
//   wr_row   : row address of the write
//   wr_data  : 8-element row, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_col   : column address of the combinational read
//   rd_data  : 8-element column, element r (= row r) at [r*DATA_WIDTH +: DATA_WIDTH]
module dct_tp_bank
  import dct_transpose_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        we,
  input  dct_idx_t                    wr_row,
  input  logic [DCT_N*DATA_WIDTH-1:0] wr_data,
  input  dct_idx_t                    rd_col,
  output logic [DCT_N*DATA_WIDTH-1:0] rd_data
);

  // No reset: contents are only observed once the bank has been fully rewritten.
  logic [DATA_WIDTH-1:0] mem_q [DCT_N][DCT_N];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < DCT_N; k++) begin
        mem_q[wr_row][k] <= wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < DCT_N; r++) begin
      rd_data[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[r][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row-pass and column-pass 1-D DCTs.
// Rows are written into one bank while the other, once full, is emitted column by column.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   in_valid   : in_row holds a valid row
//   in_ready   : a row can be accepted this cycle
//   in_row     : 8-element row, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   col_ready  : column-pass DCT can take a column this cycle
//   col_start  : one-cycle pulse, col_data valid
//   col_data   : 8-element column, element r (= row r) at [r*DATA_WIDTH +: DATA_WIDTH]
//   col_index  : column number of col_data
//   col_last   : with col_start on column 7
//   ovf        : one-cycle pulse after a row was offered while in_ready was low
module dct_transpose_buffer
  import dct_transpose_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DCT_N*DATA_WIDTH-1:0] in_row,
  input  logic                        col_ready,
  output logic                        col_start,
  output logic [DCT_N*DATA_WIDTH-1:0] col_data,
  output logic [DCT_IDX_W-1:0]        col_index,
  output logic                        col_last,
  output logic                        ovf
);

  logic [1:0]                  full_q, full_d;
  logic                        wr_bank_q, rd_bank_q;
  dct_idx_t                    wr_row_q, rd_col_q;
  logic                        col_start_q, col_last_q, ovf_q;
  logic [DCT_N*DATA_WIDTH-1:0] col_data_q;
  dct_idx_t                    col_index_q;

  logic                        wr_fire, rd_fire;
  logic [DCT_N*DATA_WIDTH-1:0] bank_col [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tp_bank #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk     (clk),
      .we      (wr_fire && (wr_bank_q == b[0])),
      .wr_row  (wr_row_q),
      .wr_data (in_row),
      .rd_col  (rd_col_q),
      .rd_data (bank_col[b])
    );
  end

  always_comb begin
    in_ready = !full_q[wr_bank_q];
    wr_fire  = in_valid && in_ready;
    rd_fire  = full_q[rd_bank_q] && col_ready;
    full_d   = full_q;
    // Write and read completions always hit different banks, so both updates apply.
    if (wr_fire && (wr_row_q == DctLastIdx)) full_d[wr_bank_q] = 1'b1;
    if (rd_fire && (rd_col_q == DctLastIdx)) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      rd_col_q    <= '0;
      col_start_q <= 1'b0;
      col_last_q  <= 1'b0;
      col_data_q  <= '0;
      col_index_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      full_q      <= full_d;
      ovf_q       <= in_valid && !in_ready;
      col_start_q <= rd_fire;
      col_last_q  <= rd_fire && (rd_col_q == DctLastIdx);
      if (wr_fire) begin
        wr_row_q <= wr_row_q + 1'b1;
        if (wr_row_q == DctLastIdx) wr_bank_q <= !wr_bank_q;
      end
      if (rd_fire) begin
        col_data_q  <= bank_col[rd_bank_q];
        col_index_q <= rd_col_q;
        rd_col_q    <= rd_col_q + 1'b1;
        if (rd_col_q == DctLastIdx) rd_bank_q <= !rd_bank_q;
      end
    end
  end

  assign col_start = col_start_q;
  assign col_data  = col_data_q;
  assign col_index = col_index_q;
  assign col_last  = col_last_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dct_transpose_buffer.sv
module tb_dct_transpose_buffer;

  localparam int W  = 16;
  localparam int VW = 8 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_row;
  logic          col_ready;
  logic          col_start;
  logic [VW-1:0] col_data;
  logic [2:0]    col_index;
  logic          col_last;
  logic          ovf;

  dct_transpose_buffer #(
    .DATA_WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .col_ready (col_ready),
    .col_start (col_start),
    .col_data  (col_data),
    .col_index (col_index),
    .col_last  (col_last),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VW-1:0] data;
    logic [2:0]    idx;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            start_log[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic          rdy_prev = 1'b0;
  logic [VW-1:0] rows [8];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rdy_prev <= col_ready;
  end

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a column.
  always @(negedge clk) begin
    exp_t e;
    if (col_start === 1'b1) begin
      start_log.push_back(cyc);
      check("start_only_after_ready", {127'd0, rdy_prev}, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_column", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("col_data", col_data, e.data);
        check("col_index", {125'd0, col_index}, {125'd0, e.idx});
        check("col_last", {127'd0, col_last}, {127'd0, e.last});
      end
    end else if (col_last !== 1'b0) begin
      check("last_without_start", {127'd0, col_last}, 0);
    end
  end

  function automatic logic [VW-1:0] mk_row(input int base, input int r);
    logic [VW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*W +: W] = 16'(base + 8 * r + k);
    return v;
  endfunction

  // Expected columns: column c element r is row r element c.
  task automatic push_block();
    exp_t e;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) e.data[r*W +: W] = rows[r][c*W +: W];
      e.idx  = 3'(c);
      e.last = (c == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one row and hold it until accepted; t_acc is the cycle it was taken in.
  task automatic write_row(input logic [VW-1:0] d, output int t_acc, output int stalls);
    logic ok;
    ok       = 1'b0;
    t_acc    = 0;
    stalls   = 0;
    in_valid = 1'b1;
    in_row   = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        t_acc = cyc;
        ok    = 1'b1;
        break;
      end
      stalls++;
    end
    check("row_accepted", {127'd0, ok}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic write_block(output int t_last, output int stalls);
    int t, s;
    stalls = 0;
    t_last = 0;
    for (int r = 0; r < 8; r++) begin
      write_row(rows[r], t, s);
      stalls += s;
      t_last = t;
    end
    push_block();
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    tick(3);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t7, st, tot, gaps;
    logic prev_rdy, seen;

    reset     = 1'b1;
    in_valid  = 1'b0;
    col_ready = 1'b0;
    in_row    = '0;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check("reset_col_start", {127'd0, col_start}, 0);
    check("reset_col_data", col_data, 0);
    check("reset_col_index", {125'd0, col_index}, 0);
    check("reset_col_last", {127'd0, col_last}, 0);
    check("reset_ovf", {127'd0, ovf}, 0);
    check("reset_in_ready", {127'd0, in_ready}, 1);
    tick(1);

    // 1: basic block, element k of row r = 8r+k, latency of two cycles.
    col_ready = 1'b1;
    start_log.delete();
    for (int r = 0; r < 8; r++) rows[r] = mk_row(0, r);
    write_block(t7, st);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (col_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("first_col_seen", {127'd0, seen}, 1);
    check("first_col_latency", cyc - t7, 2);
    tick(1);
    drain();
    check("t1_col_count", start_log.size(), 8);
    if (start_log.size() == 8) check("t1_back_to_back", start_log[7] - start_log[0], 7);

    // 2: two blocks back to back, no input stall and no output gap.
    start_log.delete();
    tot = 0;
    for (int r = 0; r < 8; r++) rows[r] = mk_row(50, r);
    write_block(t7, st);
    tot += st;
    for (int r = 0; r < 8; r++) rows[r] = mk_row(100, r);
    write_block(t7, st);
    tot += st;
    check("t2_no_input_stall", tot, 0);
    drain();
    check("t2_col_count", start_log.size(), 16);
    if (start_log.size() == 16) check("t2_no_gap", start_log[15] - start_log[0], 15);

    // 3: both banks full, overflow on a 17th row, in_ready returns after A's column 7.
    col_ready = 1'b0;
    for (int r = 0; r < 8; r++) rows[r] = mk_row(400, r);
    write_block(t7, st);
    for (int r = 0; r < 8; r++) rows[r] = mk_row(600, r);
    write_block(t7, st);
    @(negedge clk);
    check("t3_in_ready_low_when_full", {127'd0, in_ready}, 0);
    tick(1);
    in_valid = 1'b1;
    in_row   = {8{16'hDEAD}};
    tick(1);
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_ovf_pulse", {127'd0, ovf}, 1);
    @(negedge clk);
    check("t3_ovf_one_cycle", {127'd0, ovf}, 0);
    tick(1);
    col_ready = 1'b1;
    prev_rdy  = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col_start && col_last) begin
        seen = 1'b1;
        check("t3_in_ready_during_A7", {127'd0, prev_rdy}, 0);
        check("t3_in_ready_after_A7", {127'd0, in_ready}, 1);
        break;
      end
      prev_rdy = in_ready;
    end
    check("t3_A7_seen", {127'd0, seen}, 1);
    tick(1);
    drain();

    // 4: col_ready toggling; columns only on ready cycles, in order.
    col_ready = 1'b0;
    for (int r = 0; r < 8; r++) rows[r] = mk_row(800, r);
    write_block(t7, st);
    tick(2);
    start_log.delete();
    for (int i = 0; i < 24; i++) begin
      col_ready = (i % 2 == 0);
      tick(1);
    end
    col_ready = 1'b1;
    drain();
    check("t4_col_count", start_log.size(), 8);
    gaps = 0;
    for (int i = 1; i < start_log.size(); i++) if (start_log[i] - start_log[i-1] != 2) gaps++;
    check("t4_every_other_cycle", gaps, 0);

    // 5: partial block discarded by reset.
    for (int r = 0; r < 4; r++) begin
      write_row(mk_row(16'h1000, r), t7, st);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    start_log.delete();
    @(negedge clk);
    check("t5_in_ready_after_reset", {127'd0, in_ready}, 1);
    tick(1);
    for (int r = 0; r < 8; r++) rows[r] = mk_row(200, r);
    write_block(t7, st);
    drain();
    check("t5_col_count", start_log.size(), 8);

    // 6: extreme values on the diagonal stay bit-exact.
    for (int r = 0; r < 8; r++) begin
      rows[r] = '0;
      rows[r][r*W +: W] = (r % 3 == 0) ? 16'h8000 : (r % 3 == 1) ? 16'h7FFF : 16'hFFFF;
    end
    write_block(t7, st);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
